// File: rtl/beam_scan_controller.sv
// beam_scan_controller
//
// Steers the mic-array beam. On a start request it walks delay_select
// through every direction. For each direction it discards the strobes
// that refill the delay line, then sums the beam magnitude over a
// power-of-two window. When the sweep ends it locks delay_select onto
// the loudest direction.
//
// Ports
//   clk                  single clock
//   rst                  asynchronous, active-high reset
//   sample_valid         one-cycle strobe: delayed_pcm_data_* valid this cycle
//   delayed_pcm_data_0..7  signed 19-bit delayed samples from delay_module
//   start                one-cycle scan request
//   delay_select         registered steering index to delay_module
//   busy                 high from the cycle after an accepted start until done
//   done                 one-cycle pulse when the scan completes
//   best_dir             winning direction, held until the next scan starts
//   best_energy          window energy of the winning direction
//
// Handshake: start and sample_valid are single-cycle strobes with no
// back-pressure. start is taken only in IDLE and outside the done cycle;
// any other start is dropped. sample_valid counts only in SETTLE and
// ACCUM and is ignored in every other state.
module beam_scan_controller #(
    parameter int NUM_DIRS       = 3,
    parameter int SETTLE_SAMPLES = 20,
    parameter int WINDOW_LOG2    = 8,
    parameter int ENERGY_W       = 22 + WINDOW_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [18:0]         delayed_pcm_data_0,
    input  logic [18:0]         delayed_pcm_data_1,
    input  logic [18:0]         delayed_pcm_data_2,
    input  logic [18:0]         delayed_pcm_data_3,
    input  logic [18:0]         delayed_pcm_data_4,
    input  logic [18:0]         delayed_pcm_data_5,
    input  logic [18:0]         delayed_pcm_data_6,
    input  logic [18:0]         delayed_pcm_data_7,
    input  logic                start,
    output logic [4:0]          delay_select,
    output logic                busy,
    output logic                done,
    output logic [4:0]          best_dir,
    output logic [ENERGY_W-1:0] best_energy
);

    // The counter is shared by the settle phase and the accumulation window.
    localparam int CNT_W = (WINDOW_LOG2 + 1 > $clog2(SETTLE_SAMPLES + 1)) ?
                           WINDOW_LOG2 + 1 : $clog2(SETTLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'((1 << WINDOW_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [4:0]       LAST_DIR    = 5'(NUM_DIRS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, EVAL} state_t;

    state_t              state, state_d;
    logic [4:0]          dir_idx, dir_idx_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [ENERGY_W-1:0] acc, acc_d;
    logic [4:0]          delay_select_d;
    logic [4:0]          best_dir_d;
    logic [ENERGY_W-1:0] best_energy_d;
    logic                busy_d;
    logic                done_d;

    logic [21:0]         beam_sum;
    logic [21:0]         beam_mag;
    logic                win;

    // Eight 19-bit channels sign-extended to 22 bits cannot overflow. The
    // most negative sum, -2^21, negates to the unsigned value 2^21, which
    // is the correct magnitude.
    always_comb begin
        beam_sum = {{3{delayed_pcm_data_0[18]}}, delayed_pcm_data_0}
                 + {{3{delayed_pcm_data_1[18]}}, delayed_pcm_data_1}
                 + {{3{delayed_pcm_data_2[18]}}, delayed_pcm_data_2}
                 + {{3{delayed_pcm_data_3[18]}}, delayed_pcm_data_3}
                 + {{3{delayed_pcm_data_4[18]}}, delayed_pcm_data_4}
                 + {{3{delayed_pcm_data_5[18]}}, delayed_pcm_data_5}
                 + {{3{delayed_pcm_data_6[18]}}, delayed_pcm_data_6}
                 + {{3{delayed_pcm_data_7[18]}}, delayed_pcm_data_7};
        beam_mag = beam_sum[21] ? (22'd0 - beam_sum) : beam_sum;
    end

    // Direction 0 always seeds the winner. After that the compare is
    // strict, so a tie keeps the lower index.
    assign win = (dir_idx == 5'd0) || (acc > best_energy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dir_idx      <= 5'd0;
            cnt          <= '0;
            acc          <= '0;
            delay_select <= 5'd0;
            best_dir     <= 5'd0;
            best_energy  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            dir_idx      <= dir_idx_d;
            cnt          <= cnt_d;
            acc          <= acc_d;
            delay_select <= delay_select_d;
            best_dir     <= best_dir_d;
            best_energy  <= best_energy_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d        = state;
        dir_idx_d      = dir_idx;
        cnt_d          = cnt;
        acc_d          = acc;
        delay_select_d = delay_select;
        best_dir_d     = best_dir;
        best_energy_d  = best_energy;
        busy_d         = busy;
        done_d         = 1'b0;

        case (state)
            IDLE: begin
                // done is still high in the first IDLE cycle, which keeps
                // that cycle closed to a new start.
                if (start && !done) begin
                    dir_idx_d      = 5'd0;
                    delay_select_d = 5'd0;
                    best_dir_d     = 5'd0;
                    best_energy_d  = '0;
                    cnt_d          = '0;
                    busy_d         = 1'b1;
                    state_d        = SETTLE;
                end
            end

            SETTLE: begin
                if (sample_valid) begin
                    if (cnt == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
            end

            ACCUM: begin
                if (sample_valid) begin
                    acc_d = acc + ENERGY_W'(beam_mag);
                    if (cnt == WINDOW_LAST) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
            end

            EVAL: begin
                if (win) begin
                    best_dir_d    = dir_idx;
                    best_energy_d = acc;
                end
                if (dir_idx < LAST_DIR) begin
                    dir_idx_d      = dir_idx + 5'd1;
                    delay_select_d = dir_idx + 5'd1;
                    cnt_d          = '0;
                    state_d        = SETTLE;
                end else begin
                    // Lock onto the winner after this cycle's compare.
                    delay_select_d = win ? dir_idx : best_dir;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    state_d        = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/beam_scan_controller.md
# beam_scan_controller

Drives the `delay_select` input of `delay_module` and consumes its eight delayed PCM outputs. On a start request it sweeps the steering directions, measures beam energy for each, then locks `delay_select` onto the loudest direction. It sits between `delay_module` and the downstream beam consumer and closes the steering loop of the mic array.

## Interface
- `NUM_DIRS`, 3: number of directions scanned, indices 0..NUM_DIRS-1 (≤ 32).
- `SETTLE_SAMPLES`, 20: sample strobes discarded after each `delay_select` change, covering delay-line refill.
- `WINDOW_LOG2`, 8: accumulation window is 2^WINDOW_LOG2 samples.
- `ENERGY_W`, 22+WINDOW_LOG2: width of the energy accumulator.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: one-cycle strobe; the delayed data is valid in this cycle.
- `delayed_pcm_data_0` … `delayed_pcm_data_7` in 19 each: signed two's-complement delayed samples from `delay_module`.
- `start` in 1: one-cycle scan request.
- `delay_select` out 5: registered steering index to `delay_module`.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle.
- `done` out 1: one-cycle pulse when the scan completes.
- `best_dir` out 5: winning direction, held until the next scan starts.
- `best_energy` out ENERGY_W: winning window energy.

## Operation
- Beam sum: sign-extend each channel to 22 bits and add all eight. The magnitude is |sum|, 22-bit unsigned; max 2^21 at all inputs = −2^18. No saturation is needed.
- The accumulator adds the magnitude on each counted strobe. Max value is 2^21·2^WINDOW_LOG2, which fits in ENERGY_W, so it never wraps.
- States: IDLE, SETTLE, ACCUM, EVAL.
- IDLE: `busy`=0. A `start` pulse loads `dir_idx`=0, `delay_select`=0, `best_dir`=0, `best_energy`=0, clears the sample counter and moves to SETTLE.
- SETTLE: counts `sample_valid`. On the SETTLE_SAMPLES-th strobe it clears the accumulator and moves to ACCUM. That strobe is not accumulated.
- ACCUM: each strobe adds the magnitude and increments the counter. The strobe that completes the window is included, and the FSM then moves to EVAL.
- EVAL (one cycle):
  - win = (dir_idx==0) or (acc > best_energy), a strict compare, so ties keep the lower index.
  - On win, update `best_dir`/`best_energy` to dir_idx/acc.
  - If dir_idx < NUM_DIRS−1: increment dir_idx, set `delay_select`=dir_idx+1, go to SETTLE.
  - Else: set `delay_select` to the post-compare winner, pulse `done` on the next cycle, go to IDLE.
- `start` is ignored while `busy`=1 and in the `done` cycle.
- `sample_valid` is ignored in IDLE and EVAL.
- `delay_select` changes only on `start`, EVAL or reset.
- Reset at any time, including mid-scan, forces IDLE and all outputs to 0. The partial scan is discarded.

## Timing
- Reset values: `delay_select`=0, `busy`=0, `done`=0, `best_dir`=0, `best_energy`=0.
- `busy` rises in the cycle after `start` and falls in the same cycle `done` is high.
- The new `delay_select` is visible in the cycle after `start` or after EVAL.
- The final `delay_select`, `best_dir` and `best_energy` are all valid in the `done` cycle.
- Scan length: NUM_DIRS·(SETTLE_SAMPLES + 2^WINDOW_LOG2) strobes, plus NUM_DIRS EVAL cycles, plus 1 cycle.
- Strobe spacing is arbitrary, down to back-to-back. Results depend only on the strobed data, not on the gaps.

## Test plan
Bench uses `WINDOW_LOG2`=4, `SETTLE_SAMPLES`=20, `NUM_DIRS`=3. The data model returns channel values as a function of the current `delay_select`.

- **Reset:** assert `rst` mid-cycle with no clock → all outputs 0 immediately.
- **Clear winner:** dir1 drives all channels +1000, dirs 0 and 2 drive +100, strobes every cycle → `done` pulse; `best_dir`=1, `best_energy`=128000, `delay_select`=1; `busy` low in the `done` cycle.
- **Tie:** all directions drive +500 on all channels → `best_dir`=0, `best_energy`=64000, `delay_select`=0.
- **Negative full scale:** dir2 drives −262144 on all channels, others 0 → `best_dir`=2, `best_energy`=33554432, no wrap.
- **Gapped strobes and ignored start:** `sample_valid` every 4th cycle, `start` re-pulsed mid-scan → same result as the clear-winner case; exactly one `done`.
- **Reset mid-scan:** `rst` during ACCUM of dir1 → outputs 0, IDLE; a fresh `start` then completes with the clear-winner result.
